regfile_readback_seq: RTL
=========================

Name: regfile_readback_seq

Overview:
- Reader-side counterpart to the register index translator. The translator turns 4-bit register indices into 5-bit read-mux select codes (code = index+1, 0 = no register) and 16-bit one-hot write enables. This block goes the other way.
- Read path: walks a range of registers by driving 5-bit select codes into the register-file read mux, captures each value and streams it out over a valid/ready interface.
- Write path: decodes the 16-bit one-hot write-enable bus back into a 4-bit index, with error detection.
- Sits beside the register file, feeding the debug/readback path.

Parameters:
- DATA_W, 16, register data width.
- FIRST_REG, 0, first register index read in a sweep (0..15).
- LAST_REG, 15, last register index read in a sweep (FIRST_REG..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  synchronous abort of sweep.
- busy  out  1  high in READ/HOLD.
- done  out  1  one-cycle pulse at sweep completion.
- rd_sel  out  5  read-mux select code; 0 = none, index+1 otherwise.
- rd_data  in  DATA_W  read-mux output, combinational from rd_sel.
- out_valid  out  1  captured word available.
- out_ready  in  1  consumer accepts word.
- out_index  out  4  index of captured word.
- out_data  out  DATA_W  captured register value.
- out_stale  out  1  captured register was written while held.
- wr_en  in  16  one-hot register write-enable bus.
- wr_hit  out  1  registered: any wr_en bit set.
- wr_idx  out  4  registered: index of lowest set wr_en bit.
- wr_multi  out  1  registered: more than one wr_en bit set.

Behaviour:
- Reset (reset_n low, async): state=IDLE; busy, done, out_valid, out_stale, wr_hit, wr_multi = 0; rd_sel, out_index, wr_idx = 0; out_data = 0.
- FSM states: IDLE, READ, HOLD, DONE. Internal 4-bit counter idx.
- IDLE: rd_sel=0, busy=0. start=1 -> idx<=FIRST_REG, go READ. abort in IDLE has no effect.
- READ: rd_sel=idx+1 (registered, valid throughout the state). At the end of the READ cycle:
  - out_data<=rd_data, out_index<=idx, out_valid<=1, out_stale<=0;
  - go HOLD.
- HOLD: rd_sel=0; out_valid=1; out_data and out_index stable.
  - If wr_en[out_index]=1 in any HOLD cycle, out_stale<=1 (sticky until the next capture).
  - On out_valid&&out_ready: out_valid<=0. If idx==LAST_REG go DONE, else idx<=idx+1 and go READ.
  - out_ready low holds indefinitely.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Cycle timing: start at edge 0 -> rd_sel=FIRST_REG+1 during cycle 1 -> out_valid high from cycle 2. With out_ready tied high, one word every 2 cycles. done pulses the cycle after the final handshake.
- start while busy: ignored. start in DONE: ignored; a new start must be applied in IDLE.
- abort=1 in READ/HOLD/DONE:
  - next cycle state=IDLE, out_valid=0, rd_sel=0, busy=0;
  - no done pulse;
  - abort takes priority over a same-cycle handshake.
- Simultaneous write and capture: a write to register idx in the READ cycle is not flagged. Read-before-write semantics apply: the captured value is the pre-write value and out_stale=0.
- Write decoder (independent of FSM, 1-cycle latency):
  - wr_hit<=|wr_en;
  - wr_idx<=index of lowest set bit (0 when wr_en=0);
  - wr_multi<=1 when popcount(wr_en)>=2.
- Width rules: rd_sel = {1'b0,idx}+1; idx=15 yields 5'b10000. idx never wraps; the sweep ends at LAST_REG.
- FIRST_REG==LAST_REG: single-word sweep.
- Reset mid-sweep: immediate return to reset values; any partial sweep is discarded.

Test Plan:
- Full sweep with defaults, out_ready=1, register file preloaded r_i=16'hA000+i:
  - expect 16 words, out_index 0..15, out_data A000..A00F;
  - rd_sel sequence 1..16 with 0 between;
  - done pulse once at cycle 33; busy high cycles 1..32.
- Backpressure: out_ready low for 5 cycles on r3:
  - out_valid, out_index=3 and out_data held stable;
  - rd_sel=0 throughout;
  - sweep resumes with rd_sel=5 one cycle after acceptance.
- Stale flag:
  - wr_en=16'h0008 during HOLD of r3 -> out_stale=1 for that word; next word out_stale=0;
  - same write during READ of r3 -> out_stale=0.
- abort in HOLD of r7 -> next cycle IDLE, out_valid=0, no done; a subsequent start restarts at FIRST_REG.
- Write decoder: wr_en=0000 -> hit=0/idx=0/multi=0; 0001 -> 1/0/0; 8000 -> 1/15/0; 0110 -> 1/1/1. All results appear one cycle after stimulus.
- reset_n asserted mid-sweep (asynchronous, between edges) -> all outputs at reset values immediately; start ignored until reset_n high. Also run with FIRST_REG=LAST_REG=15: exactly one word, rd_sel=5'b10000.

Source files
------------

// File: rtl/regfile_readback_seq.sv
// Register-file readback sequencer: sweeps a register range through the read mux and
// streams captured words over valid/ready; also decodes the one-hot write-enable bus.
module regfile_readback_seq #(
    parameter int DATA_W    = 16,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [4:0]        rd_sel,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              out_stale,
    input  logic [15:0]       wr_en,
    output logic              wr_hit,
    output logic [3:0]        wr_idx,
    output logic              wr_multi
);

    localparam logic [3:0] FIRST_IDX = 4'(FIRST_REG);
    localparam logic [3:0] LAST_IDX  = 4'(LAST_REG);

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    state_t     state;
    logic [3:0] idx;

    // Select code 0 means "no register", so indices are offset by one.
    function automatic logic [4:0] sel_code(input logic [3:0] i);
        return {1'b0, i} + 5'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_sel    <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            out_stale <= 1'b0;
        end else if (abort && state != IDLE) begin
            // Abort wins over a same-cycle handshake and suppresses the done pulse.
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_sel    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx    <= FIRST_IDX;
                        rd_sel <= sel_code(FIRST_IDX);
                        busy   <= 1'b1;
                        state  <= READ;
                    end
                end
                READ: begin
                    out_data  <= rd_data;
                    out_index <= idx;
                    out_valid <= 1'b1;
                    out_stale <= 1'b0;
                    rd_sel    <= '0;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (wr_en[out_index])
                        out_stale <= 1'b1;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx    <= idx + 4'd1;
                            rd_sel <= sel_code(idx + 4'd1);
                            state  <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [3:0] low_idx;
    logic       multi;

    always_comb begin
        low_idx = '0;
        for (int i = 15; i >= 0; i--)
            if (wr_en[i]) low_idx = 4'(i);
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi = |(wr_en & (wr_en - 16'd1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_hit   <= 1'b0;
            wr_idx   <= '0;
            wr_multi <= 1'b0;
        end else begin
            wr_hit   <= |wr_en;
            wr_idx   <= low_idx;
            wr_multi <= multi;
        end
    end

endmodule
